py300_axi4l_cmd_master: RTL

AXI4-Lite initiator for the PY300 camera control path. It turns a simple valid/ready command stream (write or read, byte address, data, strobe) into single AXI4-Lite transactions and returns each completion on a valid/ready response stream. Bring-up and calibration logic, such as a bitslip training sequencer, use it to drive the register blocks on the `jelly3_axi4l_if` bus without embedding AXI handshaking themselves. One transaction is outstanding at a time.

---
 rtl/jelly3_axi4l_if.sv | 55 +++++
 rtl/py300_axi4l_cmd_master.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/jelly3_axi4l_if.sv
`default_nettype none
// ============================================================================
// Module   : jelly3_axi4l_if
// Brief    : AXI4-Lite bus bundle with initiator (m) and target (s) modports.
// Revision : 1.0
// ============================================================================
interface jelly3_axi4l_if #(
  parameter int ADDR_BITS = 32,
  parameter int DATA_BITS = 32,
  parameter int STRB_BITS = DATA_BITS / 8
) (
  input logic aresetn,
  input logic aclk
);

  logic [ADDR_BITS-1:0] awaddr;
  logic [2:0]           awprot;
  logic                 awvalid;
  logic                 awready;
  logic [DATA_BITS-1:0] wdata;
  logic [STRB_BITS-1:0] wstrb;
  logic                 wvalid;
  logic                 wready;
  logic [1:0]           bresp;
  logic                 bvalid;
  logic                 bready;
  logic [ADDR_BITS-1:0] araddr;
  logic [2:0]           arprot;
  logic                 arvalid;
  logic                 arready;
  logic [DATA_BITS-1:0] rdata;
  logic [1:0]           rresp;
  logic                 rvalid;
  logic                 rready;

  modport m (
    input  aresetn, aclk,
    output awaddr, awprot, awvalid, input  awready,
    output wdata, wstrb, wvalid,    input  wready,
    input  bresp, bvalid,           output bready,
    output araddr, arprot, arvalid, input  arready,
    input  rdata, rresp, rvalid,    output rready
  );

  modport s (
    input  aresetn, aclk,
    input  awaddr, awprot, awvalid, output awready,
    input  wdata, wstrb, wvalid,    output wready,
    output bresp, bvalid,           input  bready,
    input  araddr, arprot, arvalid, output arready,
    output rdata, rresp, rvalid,    input  rready
  );

endinterface
`default_nettype wire

// File: rtl/py300_axi4l_cmd_master.sv
`default_nettype none
// ============================================================================
// Module   : py300_axi4l_cmd_master
// Brief    : Valid/ready command stream to single-outstanding AXI4-Lite
//            initiator. Optional watchdog: PY300_AXI4L_CMD_MASTER_TIMEOUT_EN.
// Revision : 1.0
// ============================================================================
module py300_axi4l_cmd_master #(
  parameter int TIMEOUT_CYCLES = 1024
) (
  jelly3_axi4l_if.m                         m_axi4l,
  input  logic                              s_cmd_valid,
  output logic                              s_cmd_ready,
  input  logic                              s_cmd_write,
  input  logic [$bits(m_axi4l.awaddr)-1:0]  s_cmd_addr,
  input  logic [$bits(m_axi4l.wdata)-1:0]   s_cmd_wdata,
  input  logic [$bits(m_axi4l.wstrb)-1:0]   s_cmd_wstrb,
  output logic                              m_rsp_valid,
  input  logic                              m_rsp_ready,
  output logic                              m_rsp_write,
  output logic [$bits(m_axi4l.wdata)-1:0]   m_rsp_rdata,
  output logic [1:0]                        m_rsp_resp,
  output logic                              m_rsp_timeout,
  output logic                              busy
);

  localparam int c_addr_bits = $bits(m_axi4l.awaddr);
  localparam int c_data_bits = $bits(m_axi4l.wdata);
  localparam int c_strb_bits = $bits(m_axi4l.wstrb);

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_WR   = 3'd1,
    ST_WB   = 3'd2,
    ST_RA   = 3'd3,
    ST_RD   = 3'd4,
    ST_RSP  = 3'd5
  } state_t;

  logic clk;
  logic rst_n;
  assign clk   = m_axi4l.aclk;
  assign rst_n = m_axi4l.aresetn;

  state_t                 r_state;
  logic                   r_cmd_ready;
  logic                   r_awvalid;
  logic                   r_wvalid;
  logic                   r_bready;
  logic                   r_arvalid;
  logic                   r_rready;
  logic [c_addr_bits-1:0] r_addr;
  logic [c_data_bits-1:0] r_wdata;
  logic [c_strb_bits-1:0] r_wstrb;
  logic                   r_rsp_valid;
  logic                   r_rsp_write;
  logic [c_data_bits-1:0] r_rsp_rdata;
  logic [1:0]             r_rsp_resp;
  logic                   r_rsp_timeout;

  logic w_aw_done;
  logic w_w_done;
  logic w_wait_state;
  logic w_hs_done;
  logic w_tmo_hit;

  assign w_aw_done = !r_awvalid || m_axi4l.awready;
  assign w_w_done  = !r_wvalid  || m_axi4l.wready;

  // Completion of the handshake each waiting state is blocked on.
  always_comb begin
    w_wait_state = 1'b0;
    w_hs_done    = 1'b0;
    case (r_state)
      ST_WR:   begin w_wait_state = 1'b1; w_hs_done = w_aw_done && w_w_done; end
      ST_WB:   begin w_wait_state = 1'b1; w_hs_done = m_axi4l.bvalid;        end
      ST_RA:   begin w_wait_state = 1'b1; w_hs_done = m_axi4l.arready;       end
      ST_RD:   begin w_wait_state = 1'b1; w_hs_done = m_axi4l.rvalid;        end
      default: ;
    endcase
  end

`ifdef PY300_AXI4L_CMD_MASTER_TIMEOUT_EN
  localparam int c_cnt_bits = $clog2(TIMEOUT_CYCLES + 1);

  logic [c_cnt_bits-1:0] r_tmo_cnt;

  // IDLE is the only way into WR/RA, so clearing there restarts each transaction.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tmo_cnt <= '0;
    end else if (r_state == ST_IDLE) begin
      r_tmo_cnt <= '0;
    end else if (w_wait_state) begin
      r_tmo_cnt <= r_tmo_cnt + 1'b1;
    end
  end

  assign w_tmo_hit = (r_tmo_cnt == c_cnt_bits'(TIMEOUT_CYCLES - 1));
`else
  logic w_unused_cfg;
  assign w_unused_cfg = (TIMEOUT_CYCLES != 0);
  assign w_tmo_hit    = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= ST_IDLE;
      r_cmd_ready   <= 1'b0;
      r_awvalid     <= 1'b0;
      r_wvalid      <= 1'b0;
      r_bready      <= 1'b0;
      r_arvalid     <= 1'b0;
      r_rready      <= 1'b0;
      r_addr        <= '0;
      r_wdata       <= '0;
      r_wstrb       <= '0;
      r_rsp_valid   <= 1'b0;
      r_rsp_write   <= 1'b0;
      r_rsp_rdata   <= '0;
      r_rsp_resp    <= 2'b00;
      r_rsp_timeout <= 1'b0;
    end else if (w_wait_state && !w_hs_done && w_tmo_hit) begin
      r_awvalid     <= 1'b0;
      r_wvalid      <= 1'b0;
      r_bready      <= 1'b0;
      r_arvalid     <= 1'b0;
      r_rready      <= 1'b0;
      r_rsp_valid   <= 1'b1;
      r_rsp_rdata   <= '0;
      r_rsp_resp    <= 2'b10;
      r_rsp_timeout <= 1'b1;
      r_state       <= ST_RSP;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_cmd_ready <= 1'b1;
          if (s_cmd_valid && r_cmd_ready) begin
            r_cmd_ready   <= 1'b0;
            r_addr        <= s_cmd_addr;
            r_wdata       <= s_cmd_wdata;
            r_wstrb       <= s_cmd_wstrb;
            r_rsp_write   <= s_cmd_write;
            r_rsp_rdata   <= '0;
            r_rsp_resp    <= 2'b00;
            r_rsp_timeout <= 1'b0;
            if (s_cmd_write) begin
              r_awvalid <= 1'b1;
              r_wvalid  <= 1'b1;
              r_state   <= ST_WR;
            end else begin
              r_arvalid <= 1'b1;
              r_state   <= ST_RA;
            end
          end
        end
        ST_WR: begin
          if (m_axi4l.awready) r_awvalid <= 1'b0;
          if (m_axi4l.wready)  r_wvalid  <= 1'b0;
          if (w_aw_done && w_w_done) begin
            r_bready <= 1'b1;
            r_state  <= ST_WB;
          end
        end
        ST_WB: begin
          if (m_axi4l.bvalid) begin
            r_bready    <= 1'b0;
            r_rsp_resp  <= m_axi4l.bresp;
            r_rsp_valid <= 1'b1;
            r_state     <= ST_RSP;
          end
        end
        ST_RA: begin
          if (m_axi4l.arready) begin
            r_arvalid <= 1'b0;
            r_rready  <= 1'b1;
            r_state   <= ST_RD;
          end
        end
        ST_RD: begin
          if (m_axi4l.rvalid) begin
            r_rready    <= 1'b0;
            r_rsp_rdata <= m_axi4l.rdata;
            r_rsp_resp  <= m_axi4l.rresp;
            r_rsp_valid <= 1'b1;
            r_state     <= ST_RSP;
          end
        end
        ST_RSP: begin
          if (m_rsp_ready) begin
            r_rsp_valid <= 1'b0;
            r_cmd_ready <= 1'b1;
            r_state     <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign m_axi4l.awaddr  = r_addr;
  assign m_axi4l.awprot  = 3'b000;
  assign m_axi4l.awvalid = r_awvalid;
  assign m_axi4l.wdata   = r_wdata;
  assign m_axi4l.wstrb   = r_wstrb;
  assign m_axi4l.wvalid  = r_wvalid;
  assign m_axi4l.bready  = r_bready;
  assign m_axi4l.araddr  = r_addr;
  assign m_axi4l.arprot  = 3'b000;
  assign m_axi4l.arvalid = r_arvalid;
  assign m_axi4l.rready  = r_rready;

  assign s_cmd_ready   = r_cmd_ready;
  assign m_rsp_valid   = r_rsp_valid;
  assign m_rsp_write   = r_rsp_write;
  assign m_rsp_rdata   = r_rsp_rdata;
  assign m_rsp_resp    = r_rsp_resp;
  assign m_rsp_timeout = r_rsp_timeout;
  assign busy          = (r_state != ST_IDLE);

endmodule
`default_nettype wire
